wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Shares the single result-broadcast bus (write port toward the register file / allocator forwarding inputs) among the execution units ALU0, ALU1 and LOAD_STORE.
- Each unit hands one finished result into a private one-entry holding slot.
- A round-robin scheduler drains one slot per cycle onto the registered broadcast bus. Consumers see the bus as the familiar triple of enable, register address and data, plus the producing unit's tag.

Parameters:
- N_REQ, 3, number of requesting units. Index 0 = ALU_MASTER, 1 = ALU_SALVER, 2 = LOAD_STORE.
- DATA_W, 32, result word width.
- ADDR_W, 5, destination register address width.
- TAG_W, 2, register tag width. Tag value of requester i is i+1; 0 = UNLOCKED.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all pending results (branch mispredict).
- req_valid  in  N_REQ  per-unit result valid.
- req_ready  out  N_REQ  per-unit slot free.
- req_addr  in  N_REQ*ADDR_W  per-unit destination register, packed, unit 0 in LSBs.
- req_data  in  N_REQ*DATA_W  per-unit result, packed.
- bus_en  out  1  broadcast valid this cycle.
- bus_tag  out  TAG_W  tag of producing unit (i+1).
- bus_addr  out  ADDR_W  destination register.
- bus_data  out  DATA_W  result value.
- bus_grant  out  N_REQ  one-hot: unit whose result is on the bus this cycle.
- idle  out  1  no slot pending and bus_en low.

Behaviour:
- Reset (rst=0, asynchronous):
  - all slots empty; bus_en=0, bus_tag=0, bus_addr=0, bus_data=0, bus_grant=0.
  - round-robin pointer = 0 (unit 0 highest priority first).
  - req_ready all ones, idle=1.
- Reset mid-operation drops pending slots and any bus word without broadcast.
- Slot per unit i:
  - pend[i] plus stored addr/data.
  - req_ready[i] = !pend[i]. Purely registered state, no combinational path from req_valid or grant.
- Accept: at posedge with req_valid[i] && req_ready[i] && !flush, capture addr/data and set pend[i]. Inputs are ignored when ready is low; the unit must hold them.
- Arbitration:
  - Every posedge, among pend bits, select the first set index searching ptr, ptr+1, ... modulo N_REQ (wrap-around).
  - If one is found:
    - register its addr/data onto bus_addr/bus_data, set bus_tag=i+1, bus_grant one-hot i, bus_en=1;
    - clear pend[i];
    - ptr <= (i+1) mod N_REQ.
  - If none is pending: bus_en=0, bus_grant=0, bus_tag/addr/data hold their last value, ptr unchanged.
- Latency:
  - accept at edge k;
  - earliest broadcast is valid during the cycle after edge k+1 (2-cycle result-to-bus);
  - slot frees (ready high) after edge k+1 at the earliest.
- Throughput: one broadcast per cycle overall. A single unit alone sustains one result per 2 cycles.
- A slot is cleared only by grant. An accept into a slot being granted at the same edge cannot occur, because ready was low.
- flush=1 at an edge:
  - clears all pend bits;
  - bus_en <= 0, bus_grant <= 0;
  - no accept, ptr unchanged.
  - The bus word already on the bus during the flush cycle is unaffected (it was broadcast).
- idle = !(|pend) && !bus_en.
- Each broadcast lasts exactly one cycle. There is no bus back-pressure; consumers must accept every bus_en pulse.

Test Plan:
- Reset, then unit 1 only: addr=5, data=0x0000_00AA at edge 1.
  - bus_en=1, bus_tag=2, bus_addr=5, bus_data=0xAA, bus_grant=3'b010 for exactly one cycle after edge 2.
  - req_ready[1] low after edge 1, high after edge 2.
- All three valid at the same edge (data 0x10, 0x20, 0x30), ptr=0.
  - Broadcasts on three consecutive cycles in order tag 1, 2, 3 with the matching data.
  - idle returns to 1 after the third.
- Wrap-around: after the last grant was unit 2 (ptr=0), units 0 and 2 both pending.
  - Unit 0 goes first.
  - Next, with the pointer at 1, a fresh unit 0 and unit 2 pending: unit 2 granted before unit 0.
- Continuous request by all units for 30 cycles: each unit receives exactly 10 grants, ±1. No cycle has bus_en=0 while any pend is set.
- flush asserted while units 0 and 2 are pending and unit 1 is presenting valid.
  - Next cycle bus_en=0, all req_ready=1, idle=1.
  - No broadcast of those three values ever appears.
- Asynchronous rst pulse mid-cycle with bus_en=1:
  - outputs go to reset values immediately, without waiting for clk;
  - after release, the first accepted result is broadcast normally.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Result write-back bus arbiter.
// Each execution unit parks one finished result in a private one-entry slot.
// A round-robin scheduler moves one slot per cycle onto the registered
// broadcast bus (enable, tag, register address, data, one-hot grant).
module wb_bus_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic                     bus_en,
  output logic [TAG_W-1:0]         bus_tag,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_data,
  output logic [N_REQ-1:0]         bus_grant,
  output logic                     idle
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Wrap limit sized one bit wider than the pointer so ptr+offset cannot overflow.
  localparam logic [PTR_W:0] N_WRAP = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0] slot_addr_q [N_REQ];
  logic [DATA_W-1:0] slot_data_q [N_REQ];
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic              bus_en_q, bus_en_d;
  logic [TAG_W-1:0]  bus_tag_q, bus_tag_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic [N_REQ-1:0]  bus_grant_q, bus_grant_d;

  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [N_REQ-1:0]  accept;

  // A slot takes a new result only while empty and no flush is discarding work.
  assign accept = req_valid & ~pend_q & {N_REQ{~flush}};

  // Round-robin search: first pending slot starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [PTR_W:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= N_WRAP) cand = cand - N_WRAP;
      if (!win_found && pend_q[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next-state: grant drains one slot onto the bus, accepts fill empty slots,
  // flush discards all pending work without touching the pointer.
  always_comb begin
    pend_d      = pend_q;
    ptr_d       = ptr_q;
    bus_en_d    = 1'b0;
    bus_grant_d = '0;
    bus_tag_d   = bus_tag_q;
    bus_addr_d  = bus_addr_q;
    bus_data_d  = bus_data_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (win_found) begin
        pend_d[win_idx]      = 1'b0;
        ptr_d                = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
        bus_en_d             = 1'b1;
        bus_grant_d[win_idx] = 1'b1;
        bus_tag_d            = TAG_W'(win_idx) + TAG_W'(1);
        bus_addr_d           = slot_addr_q[win_idx];
        bus_data_d           = slot_data_q[win_idx];
      end
      // A granted slot was full, so it cannot also be accepting this edge.
      pend_d = pend_d | accept;
    end
  end

  // Control and bus registers; reset drops all pending work and any bus word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      ptr_q       <= '0;
      bus_en_q    <= 1'b0;
      bus_tag_q   <= '0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      bus_grant_q <= '0;
    end else begin
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      bus_en_q    <= bus_en_d;
      bus_tag_q   <= bus_tag_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      bus_grant_q <= bus_grant_d;
    end
  end

  // Slot payload storage; contents only matter while the pend bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
        slot_data_q[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = ~pend_q;
  assign bus_en    = bus_en_q;
  assign bus_tag   = bus_tag_q;
  assign bus_addr  = bus_addr_q;
  assign bus_data  = bus_data_q;
  assign bus_grant = bus_grant_q;
  assign idle      = ~(|pend_q) & ~bus_en_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus randomized
// traffic, all checked against a slot/queue-level reference model.
module tb_wb_bus_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            bus_en;
  logic [TW-1:0]   bus_tag;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_data;
  logic [N-1:0]    bus_grant;
  logic            idle;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .bus_en(bus_en), .bus_tag(bus_tag), .bus_addr(bus_addr),
    .bus_data(bus_data), .bus_grant(bus_grant), .idle(idle)
  );

  // Per-unit presented result
  bit          u_valid [N];
  logic [AW-1:0] u_addr [N];
  logic [DW-1:0] u_data [N];

  // Reference model state
  bit            m_pend  [N];
  logic [AW-1:0] m_saddr [N];
  logic [DW-1:0] m_sdata [N];
  bit            m_acc   [N];
  int            m_ptr;
  bit            m_en;
  int            m_tag;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit [N-1:0]    m_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_acc[i]  = 0;
    end
    m_ptr = 0; m_en = 0; m_tag = 0; m_addr = '0; m_data = '0; m_grant = '0;
  endtask

  task automatic model_step();
    bit old [N];
    int w;
    old = m_pend;
    w = -1;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    if (flush) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_en = 0;
      m_grant = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && old[j]) w = j;
      end
      if (w >= 0) begin
        m_en = 1;
        m_tag = w + 1;
        m_addr = m_saddr[w];
        m_data = m_sdata[w];
        m_grant = '0;
        m_grant[w] = 1'b1;
        m_pend[w] = 0;
        m_ptr = (w + 1) % N;
      end else begin
        m_en = 0;
        m_grant = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (u_valid[i] && !old[i]) begin
          m_acc[i] = 1;
          m_pend[i] = 1;
          m_saddr[i] = u_addr[i];
          m_sdata[i] = u_data[i];
        end
      end
    end
  endtask

  task automatic check_all();
    bit [N-1:0] rdy;
    bit any;
    any = 0;
    for (int i = 0; i < N; i++) begin
      rdy[i] = !m_pend[i];
      any = any | m_pend[i];
    end
    chk("bus_en", bus_en, m_en);
    chk("bus_tag", bus_tag, m_tag);
    chk("bus_addr", bus_addr, m_addr);
    chk("bus_data", bus_data, m_data);
    chk("bus_grant", bus_grant, m_grant);
    chk("req_ready", req_ready, rdy);
    chk("idle", idle, !any && !m_en);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = u_valid[i];
      req_addr[i*AW +: AW] = u_addr[i];
      req_data[i*DW +: DW] = u_data[i];
    end
  endtask

  task automatic tick();
    drive();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drop_accepted();
    for (int i = 0; i < N; i++) if (m_acc[i]) u_valid[i] = 0;
  endtask

  task automatic present(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    u_valid[i] = 1;
    u_addr[i] = a;
    u_data[i] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) u_valid[i] = 0;
    drive();
    #1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  int cnt [N];
  int tags [3];

  initial begin
    for (int i = 0; i < N; i++) begin
      u_valid[i] = 0; u_addr[i] = '0; u_data[i] = '0;
    end
    model_reset();

    // Reset values, then single result from unit 1
    do_reset();
    chk("rst_ready", req_ready, 3'b111);
    chk("rst_idle", idle, 1);
    present(1, 5'd5, 32'h0000_00AA);
    tick();
    chk("t1_ready1_low", req_ready[1], 0);
    drop_accepted();
    tick();
    chk("t1_en", bus_en, 1);
    chk("t1_tag", bus_tag, 2);
    chk("t1_addr", bus_addr, 5);
    chk("t1_data", bus_data, 32'hAA);
    chk("t1_grant", bus_grant, 3'b010);
    chk("t1_ready1_high", req_ready[1], 1);
    tick();
    chk("t1_en_one_cycle", bus_en, 0);

    // All three at once with ptr=0
    do_reset();
    present(0, 5'd1, 32'h10);
    present(1, 5'd2, 32'h20);
    present(2, 5'd3, 32'h30);
    tick();
    drop_accepted();
    for (int k = 0; k < 3; k++) begin
      tick();
      tags[k] = int'(bus_tag);
      chk("t2_data", bus_data, 32'h10 * (k + 1));
    end
    for (int k = 0; k < 3; k++) chk("t2_order", tags[k], k + 1);
    tick();
    chk("t2_idle", idle, 1);

    // Wrap-around: ptr=0 with units 0 and 2 pending
    present(0, 5'd7, 32'h111);
    present(2, 5'd8, 32'h222);
    tick();
    drop_accepted();
    tick();
    chk("t3_first_u0", bus_tag, 1);
    tick();
    chk("t3_then_u2", bus_tag, 3);
    // Move ptr to 1, then have units 0 and 2 pending together
    present(0, 5'd9, 32'h333);
    tick();
    drop_accepted();
    tick();
    present(0, 5'd10, 32'h444);
    present(2, 5'd11, 32'h555);
    tick();
    drop_accepted();
    tick();
    chk("t3_ptr1_u2_first", bus_tag, 3);
    tick();
    chk("t3_ptr1_u0_next", bus_tag, 1);
    tick();

    // Continuous requests from all units for 30 cycles
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      present(i, AW'($urandom), $urandom);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (bus_en && bus_grant[i]) cnt[i]++;
        if (m_acc[i]) present(i, AW'($urandom), $urandom);
      end
    end
    for (int i = 0; i < N; i++) chk("t4_fair", (cnt[i] >= 9 && cnt[i] <= 11), 1);

    // Flush while units 0 and 2 pending and unit 1 presenting
    do_reset();
    present(0, 5'd1, 32'hF00D_0001);
    present(2, 5'd3, 32'hF00D_0003);
    tick();
    drop_accepted();
    present(1, 5'd2, 32'hF00D_0002);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_en", bus_en, 0);
    chk("t5_ready", req_ready, 3'b111);
    chk("t5_idle", idle, 1);
    u_valid[1] = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_bcast", bus_en, 0);
    end

    // Asynchronous reset while a word is on the bus
    do_reset();
    present(0, 5'd4, 32'hCAFE_0000);
    tick();
    drop_accepted();
    tick();
    chk("t6_en_before", bus_en, 1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_en", bus_en, 0);
    chk("t6_async_grant", bus_grant, 0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    present(1, 5'd6, 32'h5A5A_5A5A);
    tick();
    drop_accepted();
    tick();
    chk("t6_after_en", bus_en, 1);
    chk("t6_after_data", bus_data, 32'h5A5A_5A5A);
    tick();

    // Randomized traffic with occasional flush
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) u_valid[i] = 0;
        if (!u_valid[i] && ($urandom_range(99) < 55)) present(i, AW'($urandom), $urandom);
      end
      flush = ($urandom_range(99) < 4);
      tick();
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
